adder_datapath: RTL and testbench
=================================

Name: adder_datapath

Overview:
- Datapath stage directly downstream of the adder control FSM.
- Consumes ASrcMuxSel, ALoad and OutBufSel. Returns the loop-compare flag ALt10.
- Holds counter register A and running-sum register S.
- Captures the running sum into a registered output buffer each time the FSM requests output. Flags completion of each full counting pass.

Parameters:
- WIDTH, 8, bit width of counter register A and of out_a.
- SUM_WIDTH, 12, bit width of sum register S and of out_sum.
- LIMIT, 10, loop bound; ALt10 = (A < LIMIT). Legal range 1..2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- ASrcMuxSel  input  1  A/S source select: 0 = constant 0, 1 = incremented/accumulated value.
- ALoad  input  1  load enable for A and S.
- OutBufSel  input  1  capture request for the output buffer.
- ALt10  output  1  combinational (A < LIMIT), unsigned.
- out_a  output  WIDTH  captured counter value.
- out_sum  output  SUM_WIDTH  captured running sum.
- out_valid  output  1  one-cycle pulse, high the cycle after a capture.
- pass_done  output  1  one-cycle pulse on completion of a counting pass.
- pass_cnt  output  8  number of completed passes, wraps 255 -> 0.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-pass): A, S, out_a, out_sum, pass_cnt = 0; out_valid, pass_done = 0. ALt10 = 1 during and after reset, since A=0 < LIMIT.
- Combinational: a_next = A + 1 (mod 2^WIDTH); s_next = S + zero-extended A (mod 2^SUM_WIDTH).
- Register update on rising edge:
  - ALoad=1, ASrcMuxSel=0: A <= 0, S <= 0.
  - ALoad=1, ASrcMuxSel=1: A <= a_next, S <= s_next.
  - ALoad=0: A and S hold; ASrcMuxSel is ignored.
- Output buffer:
  - OutBufSel=1 at an edge: out_a <= A; out_sum <= s_next (sum of 0..A inclusive); out_valid <= 1.
  - Otherwise out_a and out_sum hold and out_valid <= 0.
  - Latency: data and valid appear 1 cycle after the request and are stable together.
- Simultaneous OutBufSel=1 and ALoad=1: the capture uses pre-update A and S. The load proceeds normally.
- Consecutive OutBufSel cycles with A unchanged: the same value is captured again and out_valid stays high each cycle.
- Pass completion:
  - Condition at an edge: ALoad=1, ASrcMuxSel=0 and A >= LIMIT.
  - Effect: pass_done <= 1 for one cycle; pass_cnt <= pass_cnt + 1 (8-bit wrap).
  - A clear with A < LIMIT (e.g. first clear after reset) does not count.
- Wrap-around: A at 2^WIDTH-1 with increment wraps to 0 and ALt10 returns to 1. S wraps modulo 2^SUM_WIDTH. No saturation, no error flag.
- ALt10 has no registered delay; it reflects A in the same cycle A changes.
- Expected closed loop with the control FSM, LIMIT=10:
  - out_a sequence: 0..9.
  - out_sum sequence: 0,1,3,6,10,15,21,28,36,45.
  - Then one pass_done pulse, and the pass repeats.

Test Plan:
- Reset check: drive reset=0 mid-stream with A=5, S=10 -> all outputs 0 immediately (asynchronous), ALt10=1. After release, first edge with no controls -> state unchanged.
- Clear then 3 increments (ALoad=1, ASrcMuxSel=1 for 3 cycles) -> A=3, S=3 (0+1+2), ALt10=1. OutBufSel pulse -> next cycle out_a=3, out_sum=6, out_valid=1 for exactly 1 cycle.
- Closed loop with the control FSM model, LIMIT=10, 2 passes:
  - out_valid captures per pass: out_sum 0,1,3,6,10,15,21,28,36,45 with out_a 0..9.
  - Exactly 2 pass_done pulses; pass_cnt=2.
- Boundary: A=9 with increment -> A=10, ALt10=0 the same cycle. Clear -> pass_done=1 next cycle. Clear again at A=0 -> no pulse.
- Simultaneous capture and increment at A=4, S=6: OutBufSel=1, ALoad=1, ASrcMuxSel=1 -> out_a=4, out_sum=10, then A=5, S=10.
- Wrap: WIDTH=4, LIMIT=15, drive 16 increments from 0 -> A wraps to 0, ALt10 goes 0 at A=15 then back to 1. S=120 mod 2^SUM_WIDTH. 256 passes -> pass_cnt wraps to 0.

Source files
------------

// File: rtl/adder_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_datapath                                                           |
// | Counter/running-sum datapath with capture buffer and pass counter.       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module adder_datapath #(
  parameter int WIDTH     = 8,
  parameter int SUM_WIDTH = 12,
  parameter int LIMIT     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ASrcMuxSel,
  input  logic                 ALoad,
  input  logic                 OutBufSel,
  output logic                 ALt10,
  output logic [WIDTH-1:0]     out_a,
  output logic [SUM_WIDTH-1:0] out_sum,
  output logic                 out_valid,
  output logic                 pass_done,
  output logic [7:0]           pass_cnt
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     a_next;
  logic [SUM_WIDTH-1:0] s_reg;
  logic [SUM_WIDTH-1:0] s_next;
  logic                 pass_end;

  assign a_next   = a_reg + WIDTH'(1);
  assign s_next   = s_reg + SUM_WIDTH'(a_reg);
  assign ALt10    = (a_reg < LIMIT_W);
  // A clear only closes a pass once the counter has reached the loop bound.
  assign pass_end = ALoad && !ASrcMuxSel && (a_reg >= LIMIT_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg <= '0;
      s_reg <= '0;
    end else if (ALoad) begin
      if (ASrcMuxSel) begin
        a_reg <= a_next;
        s_reg <= s_next;
      end else begin
        a_reg <= '0;
        s_reg <= '0;
      end
    end
  end

  // Capture uses the pre-update A and S, so s_next is the sum 0..A inclusive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_a     <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= OutBufSel;
      if (OutBufSel) begin
        out_a   <= a_reg;
        out_sum <= s_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_done <= 1'b0;
      pass_cnt  <= 8'd0;
    end else begin
      pass_done <= pass_end;
      if (pass_end) begin
        pass_cnt <= pass_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_datapath.sv
`default_nettype none
// Testbench for adder_datapath: randomized and directed scenarios against a
// behavioural arithmetic model.
module tb_adder_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        src = 1'b0, ld = 1'b0, ob = 1'b0;
  logic        lt;
  logic [7:0]  oa;
  logic [11:0] os;
  logic        ov, pd;
  logic [7:0]  pc;

  logic        wr_src = 1'b0, wr_ld = 1'b0, wr_ob = 1'b0;
  logic        wr_lt;
  logic [3:0]  wr_oa;
  logic [11:0] wr_os;
  logic        wr_ov, wr_pd;
  logic [7:0]  wr_pc;

  int checks = 0;
  int errors = 0;

  // Model state: counter, running sum and observable outputs.
  int m_a = 0, m_s = 0, m_oa = 0, m_os = 0, m_ov = 0, m_pd = 0, m_pc = 0;

  always #5 clk = ~clk;

  adder_datapath #(.WIDTH(8), .SUM_WIDTH(12), .LIMIT(10)) dut (
    .clk(clk), .reset(reset), .ASrcMuxSel(src), .ALoad(ld), .OutBufSel(ob),
    .ALt10(lt), .out_a(oa), .out_sum(os), .out_valid(ov),
    .pass_done(pd), .pass_cnt(pc)
  );

  adder_datapath #(.WIDTH(4), .SUM_WIDTH(12), .LIMIT(15)) dut_w (
    .clk(clk), .reset(reset), .ASrcMuxSel(wr_src), .ALoad(wr_ld), .OutBufSel(wr_ob),
    .ALt10(wr_lt), .out_a(wr_oa), .out_sum(wr_os), .out_valid(wr_ov),
    .pass_done(wr_pd), .pass_cnt(wr_pc)
  );

  task automatic model_reset();
    m_a = 0; m_s = 0; m_oa = 0; m_os = 0; m_ov = 0; m_pd = 0; m_pc = 0;
  endtask

  // Drive one cycle of controls and advance the model; samples 1 time unit after the edge.
  task automatic step(input bit l, input bit s, input bit o);
    ld = l; src = s; ob = o;
    @(posedge clk);
    if (o) begin
      m_oa = m_a; m_os = (m_s + m_a) % 4096; m_ov = 1;
    end else begin
      m_ov = 0;
    end
    m_pd = (l && !s && m_a >= 10) ? 1 : 0;
    if (m_pd == 1) m_pc = (m_pc + 1) % 256;
    if (l) begin
      if (s) begin
        m_s = (m_s + m_a) % 4096; m_a = (m_a + 1) % 256;
      end else begin
        m_a = 0; m_s = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({oa, os, ov, pd, pc} !== '0) begin errors++; $display("FAIL reset_init got %h exp 0", {oa, os, ov, pd, pc}); end
    checks++; if (lt !== 1'b1) begin errors++; $display("FAIL reset_init_lt got %b exp 1", lt); end
    #3 reset = 1'b1;
    model_reset();
    step(1, 0, 0);
    repeat (5) step(1, 1, 0);
    step(0, 0, 1);
    checks++; if (oa !== 8'd5 || os !== 12'd15) begin errors++; $display("FAIL reset_prep got %0d/%0d exp 5/15", oa, os); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++; if ({oa, os, ov, pd, pc} !== '0) begin errors++; $display("FAIL reset_async got %h exp 0", {oa, os, ov, pd, pc}); end
    checks++; if (lt !== 1'b1) begin errors++; $display("FAIL reset_async_lt got %b exp 1", lt); end
    #3 reset = 1'b1;
    step(0, 0, 0);
    checks++; if ({oa, os, ov, pd, pc} !== '0 || lt !== 1'b1) begin errors++; $display("FAIL reset_hold got %h lt %b exp 0 lt 1", {oa, os, ov, pd, pc}, lt); end
    step(0, 0, 1);
    checks++; if (oa !== 8'd0 || os !== 12'd0 || ov !== 1'b1) begin errors++; $display("FAIL reset_state got %0d/%0d/%b exp 0/0/1", oa, os, ov); end
  endtask

  task automatic test_incr_capture();
    step(1, 0, 0);
    repeat (3) step(1, 1, 0);
    checks++; if (lt !== 1'b1) begin errors++; $display("FAIL incr_lt got %b exp 1", lt); end
    step(0, 0, 1);
    checks++; if (oa !== 8'd3 || os !== 12'd6 || ov !== 1'b1) begin errors++; $display("FAIL incr_capture got %0d/%0d/%b exp 3/6/1", oa, os, ov); end
    step(0, 0, 0);
    checks++; if (ov !== 1'b0 || oa !== 8'd3 || os !== 12'd6) begin errors++; $display("FAIL incr_pulse got %0d/%0d/%b exp 3/6/0", oa, os, ov); end
  endtask

  task automatic test_closed_loop();
    int pulses = 0;
    int pc0;
    int idx;
    int guard;
    pc0 = m_pc;
    step(1, 0, 0);
    if (pd === 1'b1) pulses++;
    for (int p = 0; p < 2; p++) begin
      idx = 0; guard = 0;
      while (lt === 1'b1 && guard < 20) begin
        step(1, 1, 1);
        checks++; if (oa !== 8'(idx) || os !== 12'(idx * (idx + 1) / 2) || ov !== 1'b1) begin errors++; $display("FAIL loop_capture got %0d/%0d/%b exp %0d/%0d/1", oa, os, ov, idx, idx * (idx + 1) / 2); end
        idx++; guard++;
      end
      checks++; if (idx != 10) begin errors++; $display("FAIL loop_length got %0d exp 10", idx); end
      step(1, 0, 0);
      if (pd === 1'b1) pulses++;
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL loop_pulses got %0d exp 2", pulses); end
    checks++; if (pc !== 8'((pc0 + 2) % 256)) begin errors++; $display("FAIL loop_pass_cnt got %0d exp %0d", pc, (pc0 + 2) % 256); end
  endtask

  task automatic test_boundary();
    step(1, 0, 0);
    repeat (9) step(1, 1, 0);
    checks++; if (lt !== 1'b1) begin errors++; $display("FAIL bound_a9_lt got %b exp 1", lt); end
    step(1, 1, 0);
    checks++; if (lt !== 1'b0) begin errors++; $display("FAIL bound_a10_lt got %b exp 0", lt); end
    step(1, 0, 0);
    checks++; if (pd !== 1'b1) begin errors++; $display("FAIL bound_pass got %b exp 1", pd); end
    step(1, 0, 0);
    checks++; if (pd !== 1'b0) begin errors++; $display("FAIL bound_nopass got %b exp 0", pd); end
  endtask

  task automatic test_simultaneous();
    step(1, 0, 0);
    repeat (4) step(1, 1, 0);
    step(1, 1, 1);
    checks++; if (oa !== 8'd4 || os !== 12'd10) begin errors++; $display("FAIL simul_capture got %0d/%0d exp 4/10", oa, os); end
    step(0, 0, 1);
    checks++; if (oa !== 8'd5 || os !== 12'd15) begin errors++; $display("FAIL simul_after got %0d/%0d exp 5/15", oa, os); end
  endtask

  task automatic test_back_to_back();
    step(0, 1, 1);
    checks++; if (oa !== 8'd5 || os !== 12'd15 || ov !== 1'b1) begin errors++; $display("FAIL b2b_first got %0d/%0d/%b exp 5/15/1", oa, os, ov); end
    step(0, 0, 1);
    checks++; if (oa !== 8'd5 || os !== 12'd15 || ov !== 1'b1) begin errors++; $display("FAIL b2b_second got %0d/%0d/%b exp 5/15/1", oa, os, ov); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0);
      checks++; if (lt !== ((m_a < 10) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL rand_lt got %b at iter %0d", lt, i); end
      checks++; if (ov !== 1'(m_ov) || pd !== 1'(m_pd)) begin errors++; $display("FAIL rand_flags got %b/%b exp %0d/%0d", ov, pd, m_ov, m_pd); end
      checks++; if (oa !== 8'(m_oa) || os !== 12'(m_os) || pc !== 8'(m_pc)) begin errors++; $display("FAIL rand_data got %0d/%0d/%0d exp %0d/%0d/%0d", oa, os, pc, m_oa, m_os, m_pc); end
    end
  endtask

  task automatic test_pass_wrap();
    int pulses = 0;
    int pc0;
    pc0 = m_pc;
    step(1, 0, 0);
    if (pd === 1'b1) pulses++;
    for (int p = 0; p < 256; p++) begin
      repeat (10) step(1, 1, 0);
      step(1, 0, 0);
      if (pd === 1'b1) pulses++;
    end
    pc0 = (m_a >= 0) ? pc0 : 0;
    checks++; if (pulses < 256 || pulses > 257) begin errors++; $display("FAIL wrap_pulses got %0d exp 256..257", pulses); end
    checks++; if (pc !== 8'(m_pc)) begin errors++; $display("FAIL wrap_pass_cnt got %0d exp %0d", pc, m_pc); end
    checks++; if (pc !== 8'((pc0 + pulses) % 256)) begin errors++; $display("FAIL wrap_pass_cnt_mod got %0d exp %0d", pc, (pc0 + pulses) % 256); end
  endtask

  task automatic test_wrap_width();
    int exp_a;
    ld = 1'b0; src = 1'b0; ob = 1'b0;
    wr_ld = 1'b1; wr_src = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      wr_src = 1'b1;
      @(posedge clk); #1;
      exp_a = (i + 1) % 16;
      checks++; if (wr_lt !== ((exp_a < 15) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL w4_lt got %b at A=%0d", wr_lt, exp_a); end
    end
    wr_ld = 1'b0; wr_ob = 1'b1;
    @(posedge clk); #1;
    wr_ob = 1'b0;
    checks++; if (wr_oa !== 4'd0 || wr_os !== 12'd120 || wr_ov !== 1'b1) begin errors++; $display("FAIL w4_capture got %0d/%0d/%b exp 0/120/1", wr_oa, wr_os, wr_ov); end
  endtask

  initial begin
    test_reset();
    test_incr_capture();
    test_closed_loop();
    test_boundary();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_pass_wrap();
    test_wrap_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
